// File: rtl/mips_ex_alu_unit.sv
// MIPS execute-stage arithmetic: ALU-control decode, WIDTH-bit ALU with zero flag, PC increment,
// and a one-cycle registered copy of the result. Optional signed overflow flag: ALU_OVERFLOW_DETECT_EN.
module mips_ex_alu_unit #(
   parameter int WIDTH  = 32,
   parameter int PC_INC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       aluop,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] pc_in,
   output logic [3:0]       aluctrl,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] result_q,
   output logic             zero_q,
   output logic             valid_q,
   output logic             overflow
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   logic [WIDTH-1:0] sumRes;
   logic [WIDTH-1:0] diffRes;
   logic             sltBit;

   // Unlisted R-type funct codes fall back to add so decode never yields X.
   always_comb begin
      aluctrl = OP_ADD;
      case (aluop)
         2'b00: aluctrl = OP_ADD;
         2'b01: aluctrl = OP_SUB;
         2'b11: aluctrl = OP_OR;
         2'b10: begin
            case (func)
               6'b100000: aluctrl = OP_ADD;
               6'b100010: aluctrl = OP_SUB;
               6'b100100: aluctrl = OP_AND;
               6'b100101: aluctrl = OP_OR;
               6'b101010: aluctrl = OP_SLT;
               6'b100111: aluctrl = OP_NOR;
               default:   aluctrl = OP_ADD;
            endcase
         end
         default: aluctrl = OP_ADD;
      endcase
   end

   assign sumRes  = in1 + in2;
   assign diffRes = in1 - in2;
   assign sltBit  = $signed(in1) < $signed(in2);

   always_comb begin
      alu_out = '0;
      case (aluctrl)
         OP_AND:  alu_out = in1 & in2;
         OP_OR:   alu_out = in1 | in2;
         OP_ADD:  alu_out = sumRes;
         OP_SUB:  alu_out = diffRes;
         OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, sltBit};
         OP_NOR:  alu_out = ~(in1 | in2);
         default: alu_out = '0;
      endcase
   end

   assign zero     = (alu_out == '0);
   assign pc_plus4 = pc_in + WIDTH'(PC_INC);

`ifdef ALU_OVERFLOW_DETECT_EN
   logic addOvf;
   logic subOvf;
   assign addOvf   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sumRes[WIDTH-1] != in1[WIDTH-1]);
   assign subOvf   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diffRes[WIDTH-1] != in1[WIDTH-1]);
   assign overflow = ((aluctrl == OP_ADD) && addOvf) || ((aluctrl == OP_SUB) && subOvf);
`else
   assign overflow = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= en;
         if (en) begin
            result_q <= alu_out;
            zero_q   <= zero;
         end
      end
   end

endmodule

// File: tb/tb_mips_ex_alu_unit.sv
// Self-checking bench for mips_ex_alu_unit: directed cases plus randomized ops against a reference model.
module tb_mips_ex_alu_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [1:0]  aluop;
   logic [5:0]  func;
   logic [31:0] in1, in2, pcIn;
   logic [3:0]  aluctrl;
   logic [31:0] aluOut, pcPlus4, resultQ;
   logic        zero, zeroQ, validQ, overflow;

   int checks   = 0;
   int failures = 0;

   logic [31:0] expResQ;
   logic        expZeroQ, expValidQ;

   mips_ex_alu_unit #(.WIDTH(32), .PC_INC(4)) dut (
      .clk(clk), .rst(rst), .en(en), .aluop(aluop), .func(func),
      .in1(in1), .in2(in2), .pc_in(pcIn), .aluctrl(aluctrl),
      .alu_out(aluOut), .zero(zero), .pc_plus4(pcPlus4),
      .result_q(resultQ), .zero_q(zeroQ), .valid_q(validQ), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] refCtrl(logic [1:0] op, logic [5:0] f);
      if (op == 2'd0) return 4'd2;
      if (op == 2'd1) return 4'd6;
      if (op == 2'd3) return 4'd1;
      if (f == 6'd32) return 4'd2;
      if (f == 6'd34) return 4'd6;
      if (f == 6'd36) return 4'd0;
      if (f == 6'd37) return 4'd1;
      if (f == 6'd42) return 4'd7;
      if (f == 6'd39) return 4'd12;
      return 4'd2;
   endfunction

   function automatic logic [31:0] refAlu(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (c == 4'd0)  return a & b;
      if (c == 4'd1)  return a | b;
      if (c == 4'd2)  return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      if (c == 4'd6)  return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      if (c == 4'd7)  return (sa < sb) ? 32'd1 : 32'd0;
      if (c == 4'd12) return ~(a | b);
      return 32'd0;
   endfunction

   function automatic logic refOvf(logic [3:0] c, logic [31:0] a, logic [31:0] b);
`ifdef ALU_OVERFLOW_DETECT_EN
      longint r;
      if (c == 4'd2) r = longint'($signed(a)) + longint'($signed(b));
      else if (c == 4'd6) r = longint'($signed(a)) - longint'($signed(b));
      else return 1'b0;
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
      return 1'b0 & (c[0] ^ a[0] ^ b[0]);
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check combinational outputs for whatever inputs are currently applied.
   task automatic chkComb(input string tag);
      logic [3:0]  c;
      logic [31:0] r;
      #1;
      c = refCtrl(aluop, func);
      r = refAlu(c, in1, in2);
      chk({tag, ".ctrl"}, {28'd0, aluctrl}, {28'd0, c});
      chk({tag, ".alu"},  aluOut, r);
      chk({tag, ".zero"}, {31'd0, zero}, {31'd0, (r == 32'd0)});
      chk({tag, ".ovf"},  {31'd0, overflow}, {31'd0, refOvf(c, in1, in2)});
      chk({tag, ".pc"},   pcPlus4, 32'((longint'(pcIn) + 4) % 64'h1_0000_0000));
   endtask

   // Advance one clock and check the registered outputs against the model.
   task automatic tick(input string tag);
      logic [31:0] r;
      r = refAlu(refCtrl(aluop, func), in1, in2);
      if (rst) begin
         expValidQ = en;
         if (en) begin
            expResQ  = r;
            expZeroQ = (r == 32'd0);
         end
      end
      @(posedge clk);
      #1;
      chk({tag, ".resq"},  resultQ, expResQ);
      chk({tag, ".zeroq"}, {31'd0, zeroQ}, {31'd0, expZeroQ});
      chk({tag, ".validq"}, {31'd0, validQ}, {31'd0, expValidQ});
   endtask

   task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic e);
      aluop = op; func = f; in1 = a; in2 = b; en = e;
   endtask

   initial begin
      rst = 1'b0; pcIn = 32'd0;
      drive(2'b10, 6'b100000, 32'd5, 32'd7, 1'b1);
      expResQ = 32'd0; expZeroQ = 1'b0; expValidQ = 1'b0;
      #2;
      chk("rst.resq", resultQ, 32'd0);
      chk("rst.zeroq", {31'd0, zeroQ}, 32'd0);
      chk("rst.validq", {31'd0, validQ}, 32'd0);
      chkComb("rst.comb");
      chk("add.alu12", aluOut, 32'd12);
      @(negedge clk);
      rst = 1'b1;

      tick("add");
      chk("add.resq12", resultQ, 32'd12);
      chk("add.valid1", {31'd0, validQ}, 32'd1);

      // en=0 holds result, valid drops
      drive(2'b01, 6'd0, 32'h1234, 32'h1234, 1'b0);
      chkComb("beq");
      chk("beq.zero", {31'd0, zero}, 32'd1);
      tick("hold");
      chk("hold.resq", resultQ, 32'd12);

      drive(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 1'b1);
      chkComb("slt");
      chk("slt.true", aluOut, 32'd1);
      drive(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 1'b1);
      chkComb("sltswap");
      chk("slt.false", aluOut, 32'd0);
      drive(2'b10, 6'b100111, 32'h0F0F_0000, 32'h0000_00F0, 1'b1);
      chkComb("nor");
      chk("nor.val", aluOut, 32'hF0F0_FF0F);
      drive(2'b10, 6'b111111, 32'd3, 32'd4, 1'b1);
      chkComb("deflt");
      chk("deflt.ctrl", {28'd0, aluctrl}, 32'd2);
      pcIn = 32'hFFFF_FFFC;
      chkComb("pcwrap");
      chk("pcwrap.val", pcPlus4, 32'd0);
      drive(2'b00, 6'd0, 32'h7FFF_FFFF, 32'd1, 1'b1);
      chkComb("ovfadd");
      chk("ovfadd.val", aluOut, 32'h8000_0000);

      // async reset between edges with result_q = 12
      drive(2'b10, 6'b100000, 32'd5, 32'd7, 1'b1);
      tick("pre");
      #2;
      rst = 1'b0;
      #1;
      chk("arst.resq", resultQ, 32'd0);
      chk("arst.zeroq", {31'd0, zeroQ}, 32'd0);
      chk("arst.validq", {31'd0, validQ}, 32'd0);
      chk("arst.comb", aluOut, 32'd12);
      expResQ = 32'd0; expZeroQ = 1'b0; expValidQ = 1'b0;
      tick("inrst");
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 400; i++) begin
         logic [5:0] fs [7];
         logic [31:0] a, b;
         fs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0};
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? a : $urandom;
         if ($urandom_range(0, 3) == 0) a = {a[31], 31'h7FFF_FFFF} ^ {1'b0, 31'($urandom_range(0, 2))};
         drive(2'($urandom), ($urandom_range(0, 3) == 0) ? 6'($urandom) : fs[$urandom_range(0, 5)],
               a, b, 1'($urandom));
         pcIn = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         chkComb("rnd");
         tick("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
